// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one LINE_DW-wide data-memory port between the CPU system bus
// (CPU_DW-wide, byte-masked) and the GEMM accelerator (full lines). GEMM has
// priority. A starvation counter forces a CPU win once the CPU has been denied
// STARVE_MAX consecutive cycles. Read data returns one cycle after the grant
// and is steered to whichever requester issued the read.
//
// Ports
//   clk, rst                 clock (rising edge) / async active-low reset
//   cpu_en/rdwr/mask/addr    CPU request; cpu_addr[1:0] ignored
//   cpu_wr_data              CPU write word
//   cpu_stall                CPU request present but not granted this cycle
//   cpu_rd_valid/rd_data     CPU read return (selected lane of the line)
//   gemm_en/rdwr/addr        GEMM request; gemm_addr[3:0] ignored
//   gemm_wr_data             GEMM write line
//   gemm_gnt                 GEMM request accepted this cycle
//   gemm_rd_valid/rd_data    GEMM read return (full line)
//   mem_en/rdwr/addr         memory access, line-aligned address
//   mem_byte_en/wr_data      per-byte write enable / write line
//   mem_rd_data              read line, valid one cycle after a read
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int CPU_DW     = 32,
    parameter int LINE_DW    = 128,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_en,
    input  logic                 cpu_rdwr,
    input  logic [CPU_DW/8-1:0]  cpu_mask,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [CPU_DW-1:0]    cpu_wr_data,
    output logic                 cpu_stall,
    output logic                 cpu_rd_valid,
    output logic [CPU_DW-1:0]    cpu_rd_data,
    input  logic                 gemm_en,
    input  logic                 gemm_rdwr,
    input  logic [ADDR_W-1:0]    gemm_addr,
    input  logic [LINE_DW-1:0]   gemm_wr_data,
    output logic                 gemm_gnt,
    output logic                 gemm_rd_valid,
    output logic [LINE_DW-1:0]   gemm_rd_data,
    output logic                 mem_en,
    output logic                 mem_rdwr,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_DW/8-1:0] mem_byte_en,
    output logic [LINE_DW-1:0]   mem_wr_data,
    input  logic [LINE_DW-1:0]   mem_rd_data
);

    localparam int LANES     = LINE_DW / CPU_DW;
    localparam int LANE_W    = $clog2(LANES);
    localparam int BE_W      = LINE_DW / 8;
    localparam int CPU_BE_W  = CPU_DW / 8;
    localparam int OFF_W     = $clog2(BE_W);      // byte offset within a line
    localparam int CPU_OFF_W = $clog2(CPU_BE_W);  // byte offset within a word
    localparam int CNT_W     = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ARB_GEMM      = 1'b0,
        ARB_CPU_FORCE = 1'b1
    } arb_state_t;

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_cpu_rd_valid;
    logic              r_gemm_rd_valid;
    logic [LANE_W-1:0] r_rd_lane;

    logic              w_cpu_gnt;
    logic              w_gemm_gnt;
    logic              w_cpu_denied;
    logic [LANE_W-1:0] w_cpu_lane;
    logic [BE_W-1:0]   w_cpu_byte_en;
    logic              w_unused_addr_bits;

    // Sub-line address bits carry no information for a line-wide port.
    assign w_unused_addr_bits = ^{cpu_addr[CPU_OFF_W-1:0], gemm_addr[OFF_W-1:0]};

    // ------------------------------------------------------------------------
    // Grant: GEMM normally wins; once forced, the CPU wins.
    // ------------------------------------------------------------------------
    assign w_cpu_gnt    = (r_state == ARB_CPU_FORCE) ? cpu_en : (cpu_en & ~gemm_en);
    assign w_gemm_gnt   = gemm_en & ~w_cpu_gnt;
    assign w_cpu_denied = cpu_en & ~w_cpu_gnt;

    assign cpu_stall = w_cpu_denied;
    assign gemm_gnt  = w_gemm_gnt;

    // CPU word position inside the line, and its byte mask shifted onto it.
    assign w_cpu_lane    = cpu_addr[OFF_W-1:CPU_OFF_W];
    assign w_cpu_byte_en = BE_W'(cpu_mask) << {w_cpu_lane, {CPU_OFF_W{1'b0}}};

    // ------------------------------------------------------------------------
    // Memory drive for the granted requester only.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        mem_en      = 1'b0;
        mem_rdwr    = 1'b0;
        mem_addr    = '0;
        mem_byte_en = '0;
        mem_wr_data = '0;
        if (w_cpu_gnt) begin
            mem_en      = 1'b1;
            mem_rdwr    = cpu_rdwr;
            mem_addr    = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_byte_en = cpu_rdwr ? w_cpu_byte_en : '0;
            mem_wr_data = {LANES{cpu_wr_data}};
        end else if (w_gemm_gnt) begin
            mem_en      = 1'b1;
            mem_rdwr    = gemm_rdwr;
            mem_addr    = {gemm_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_byte_en = gemm_rdwr ? {BE_W{1'b1}} : '0;
            mem_wr_data = gemm_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration state, starvation counter and read-return tag.
    // ------------------------------------------------------------------------
    // NOTE: only control state is reset; the data path has no storage of its
    // own, so nothing wide needs clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= ARB_GEMM;
            r_starve_cnt    <= '0;
            r_cpu_rd_valid  <= 1'b0;
            r_gemm_rd_valid <= 1'b0;
            r_rd_lane       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            if (w_cpu_denied) begin
                if (r_starve_cnt != CNT_W'(STARVE_MAX))
                    r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end

            unique case (r_state)
                // Denial number STARVE_MAX forces the next cycle to the CPU.
                ARB_GEMM:
                    if (w_cpu_denied && r_starve_cnt == CNT_W'(STARVE_MAX - 1))
                        r_state <= ARB_CPU_FORCE;
                ARB_CPU_FORCE:
                    if (w_cpu_gnt || !cpu_en)
                        r_state <= ARB_GEMM;
                default:
                    r_state <= ARB_GEMM;
            endcase

            r_cpu_rd_valid  <= w_cpu_gnt & ~cpu_rdwr;
            r_gemm_rd_valid <= w_gemm_gnt & ~gemm_rdwr;
            if (w_cpu_gnt && !cpu_rdwr)
                r_rd_lane <= w_cpu_lane;
        end
    end

    assign cpu_rd_valid  = r_cpu_rd_valid;
    assign gemm_rd_valid = r_gemm_rd_valid;
    assign cpu_rd_data   = mem_rd_data[CPU_DW*r_rd_lane +: CPU_DW];
    assign gemm_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a small line memory behind the
// port. Line i is preloaded so word w reads 32'hA000_0000 | (i << 8) | w,
// which makes every expected read value computable by hand.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst;
    logic         cpu_en;
    logic         cpu_rdwr;
    logic [3:0]   cpu_mask;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wr_data;
    logic         cpu_stall;
    logic         cpu_rd_valid;
    logic [31:0]  cpu_rd_data;
    logic         gemm_en;
    logic         gemm_rdwr;
    logic [31:0]  gemm_addr;
    logic [127:0] gemm_wr_data;
    logic         gemm_gnt;
    logic         gemm_rd_valid;
    logic [127:0] gemm_rd_data;
    logic         mem_en;
    logic         mem_rdwr;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_byte_en;
    logic [127:0] mem_wr_data;
    logic [127:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .CPU_DW(32), .LINE_DW(128), .STARVE_MAX(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_en(cpu_en), .cpu_rdwr(cpu_rdwr), .cpu_mask(cpu_mask),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data), .cpu_stall(cpu_stall),
        .cpu_rd_valid(cpu_rd_valid), .cpu_rd_data(cpu_rd_data),
        .gemm_en(gemm_en), .gemm_rdwr(gemm_rdwr), .gemm_addr(gemm_addr),
        .gemm_wr_data(gemm_wr_data), .gemm_gnt(gemm_gnt),
        .gemm_rd_valid(gemm_rd_valid), .gemm_rd_data(gemm_rd_data),
        .mem_en(mem_en), .mem_rdwr(mem_rdwr), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line memory indexed by addr[9:4]; one-cycle read latency.
    logic [127:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++)
            for (int w = 0; w < 4; w++)
                mem[i][32*w +: 32] = 32'hA000_0000 | (i << 8) | w;
        mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rdwr) begin
                for (int b = 0; b < 16; b++)
                    if (mem_byte_en[b]) mem[mem_addr[9:4]][8*b +: 8] <= mem_wr_data[8*b +: 8];
            end else begin
                mem_rd_data <= mem[mem_addr[9:4]];
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_req(input logic en, input logic rdwr, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_en = en; cpu_rdwr = rdwr; cpu_mask = mask; cpu_addr = addr; cpu_wr_data = wdata;
    endtask

    task automatic gemm_req(input logic en, input logic rdwr, input logic [31:0] addr);
        gemm_en = en; gemm_rdwr = rdwr; gemm_addr = addr;
    endtask

    initial begin
        rst = 1'b0;
        gemm_wr_data = '0;
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        gemm_req(0, 0, 32'h0);

        // Reset state
        @(negedge clk);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_cpu_rd_valid", cpu_rd_valid, 1'b0);
        check("rst_gemm_rd_valid", gemm_rd_valid, 1'b0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        // 1: simultaneous reads, GEMM first, CPU next, CPU lane 1 returned
        gemm_req(1, 0, 32'h1000_0020);
        cpu_req(1, 0, 4'h0, 32'h1000_0044, 32'h0);
        @(negedge clk);
        check("t1_gemm_gnt", gemm_gnt, 1'b1);
        check("t1_cpu_stall", cpu_stall, 1'b1);
        check("t1_mem_addr_gemm", mem_addr, 32'h1000_0020);
        check("t1_rd_byte_en", mem_byte_en, 16'h0000);
        next_cycle();
        gemm_req(0, 0, 32'h0);
        @(negedge clk);
        check("t1_cpu_granted", cpu_stall, 1'b0);
        check("t1_mem_addr_cpu", mem_addr, 32'h1000_0040);
        check("t1_gemm_rd_valid", gemm_rd_valid, 1'b1);
        check("t1_gemm_rd_data", gemm_rd_data, 128'hA0000203_A0000202_A0000201_A0000200);
        next_cycle();
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t1_cpu_rd_valid", cpu_rd_valid, 1'b1);
        check("t1_cpu_rd_data", cpu_rd_data, 32'hA000_0401);
        check("t1_gemm_rd_valid_off", gemm_rd_valid, 1'b0);
        next_cycle();

        // 2: CPU masked write to lane 2 of line 0, then read it back
        cpu_req(1, 1, 4'b0011, 32'h0000_0008, 32'hAABB_CCDD);
        @(negedge clk);
        check("t2_byte_en", mem_byte_en, 16'h0300);
        check("t2_mem_addr", mem_addr, 32'h0);
        check("t2_mem_rdwr", mem_rdwr, 1'b1);
        check("t2_wr_data", mem_wr_data, {4{32'hAABB_CCDD}});
        next_cycle();
        cpu_req(1, 0, 4'h0, 32'h0000_0008, 32'h0);
        @(negedge clk);
        check("t2_no_rd_valid_after_wr", cpu_rd_valid, 1'b0);
        next_cycle();
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t2_readback", cpu_rd_data, 32'hA000_CCDD);
        next_cycle();

        // 3: starvation, CPU forced on its 9th waiting cycle
        gemm_req(1, 0, 32'h0000_0100);
        cpu_req(1, 0, 4'h0, 32'h0000_0030, 32'h0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("t3_cpu_stall_c%0d", i), cpu_stall, (i != 9));
            check($sformatf("t3_gemm_gnt_c%0d", i), gemm_gnt, (i != 9));
            check($sformatf("t3_gemm_rd_valid_c%0d", i), gemm_rd_valid, (i != 1));
            next_cycle();
        end
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t3_gemm_resumes", gemm_gnt, 1'b1);
        check("t3_cpu_rd_valid", cpu_rd_valid, 1'b1);
        check("t3_cpu_rd_data", cpu_rd_data, 32'hA000_0300);
        check("t3_gemm_rd_valid_gap", gemm_rd_valid, 1'b0);
        next_cycle();
        for (int i = 11; i <= 20; i++) next_cycle();
        @(negedge clk);
        check("t3_gemm_gnt_c21", gemm_gnt, 1'b1);
        next_cycle();
        gemm_req(0, 0, 32'h0);

        // 6: no requests
        next_cycle();
        @(negedge clk);
        check("t6_mem_en", mem_en, 1'b0);
        check("t6_cpu_stall", cpu_stall, 1'b0);
        check("t6_gemm_gnt", gemm_gnt, 1'b0);
        check("t6_cpu_rd_valid", cpu_rd_valid, 1'b0);
        check("t6_gemm_rd_valid", gemm_rd_valid, 1'b0);
        next_cycle();

        // 4: alternating GEMM/CPU reads back-to-back
        gemm_req(1, 0, 32'h0000_0050);
        @(negedge clk);
        check("t4_a_gemm_gnt", gemm_gnt, 1'b1);
        next_cycle();
        gemm_req(0, 0, 32'h0);
        cpu_req(1, 0, 4'h0, 32'h0000_0064, 32'h0);
        @(negedge clk);
        check("t4_b_gemm_rd_valid", gemm_rd_valid, 1'b1);
        check("t4_b_gemm_rd_data", gemm_rd_data, 128'hA0000503_A0000502_A0000501_A0000500);
        check("t4_b_cpu_rd_valid", cpu_rd_valid, 1'b0);
        next_cycle();
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        gemm_req(1, 0, 32'h0000_0070);
        @(negedge clk);
        check("t4_c_cpu_rd_valid", cpu_rd_valid, 1'b1);
        check("t4_c_cpu_rd_data", cpu_rd_data, 32'hA000_0601);
        check("t4_c_gemm_rd_valid", gemm_rd_valid, 1'b0);
        next_cycle();
        gemm_req(0, 0, 32'h0);
        cpu_req(1, 0, 4'h0, 32'h0000_008C, 32'h0);
        @(negedge clk);
        check("t4_d_gemm_rd_data", gemm_rd_data, 128'hA0000703_A0000702_A0000701_A0000700);
        check("t4_d_gemm_rd_valid", gemm_rd_valid, 1'b1);
        check("t4_d_cpu_rd_valid", cpu_rd_valid, 1'b0);
        next_cycle();
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t4_e_cpu_rd_valid", cpu_rd_valid, 1'b1);
        check("t4_e_cpu_rd_data", cpu_rd_data, 32'hA000_0803);
        check("t4_e_gemm_rd_valid", gemm_rd_valid, 1'b0);
        next_cycle();

        // 5: reset hits while a granted CPU read is in flight
        cpu_req(1, 0, 4'h0, 32'h0000_0014, 32'h0);
        @(negedge clk);
        check("t5_cpu_granted", mem_en & ~cpu_stall, 1'b1);
        rst = 1'b0;
        next_cycle();
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("t5_rd_valid_discarded", cpu_rd_valid, 1'b0);
        rst = 1'b1;
        next_cycle();
        gemm_req(1, 0, 32'h0000_0020);
        cpu_req(1, 0, 4'h0, 32'h0000_0024, 32'h0);
        @(negedge clk);
        check("t5_state_gemm_prio", gemm_gnt, 1'b1);
        check("t5_cpu_stall", cpu_stall, 1'b1);
        next_cycle();
        gemm_req(0, 0, 32'h0);
        cpu_req(0, 0, 4'h0, 32'h0, 32'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
